// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - flow-controlled instruction fetch sequencer with redirect handling and decode buffer
module fetch_controller #(
  parameter int              PC_W      = 30,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            jump_en,
  input  logic [PC_W-1:0] jump_addr,
  output logic            imem_req,
  output logic [31:0]     imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [PC_W-1:0] out_pc,
  output logic            busy
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]  req_pc_q, req_pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PC_W-1:0]  buf_pc_q    [BUF_DEPTH];
  logic [PC_W-1:0]  buf_pc_d    [BUF_DEPTH];
  logic [31:0]      buf_instr_q [BUF_DEPTH];
  logic [31:0]      buf_instr_d [BUF_DEPTH];

  logic             pop;
  logic             push;
  logic [CNT_W-1:0] count_after_pop;
  logic [PC_W-1:0]  next_pc;

  // Data returned while a redirect is in flight is never pushed.
  assign out_valid       = (count_q != '0);
  assign pop             = out_valid && out_ready;
  assign push            = (state_q == FETCH) && imem_ack && !jump_en;
  assign count_after_pop = count_q - CNT_W'(pop);
  assign next_pc         = req_pc_q + PC_W'(1);

  assign imem_req  = (state_q != IDLE);
  assign busy      = (state_q != IDLE);
  assign imem_addr = 32'({req_pc_q, 2'b00});
  assign out_instr = out_valid ? buf_instr_q[rd_ptr_q] : '0;
  assign out_pc    = out_valid ? buf_pc_q[rd_ptr_q] : '0;

  // Next-state, PC sequencing and buffer bookkeeping; a redirect flush overrides pop and push.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    count_d    = count_after_pop + CNT_W'(push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    buf_pc_d   = buf_pc_q;
    buf_instr_d = buf_instr_q;

    if (push) begin
      buf_pc_d[wr_ptr_q]    = req_pc_q;
      buf_instr_d[wr_ptr_q] = imem_rdata;
    end

    case (state_q)
      IDLE: begin
        if (jump_en) begin
          fetch_pc_d = jump_addr;
        end else if (count_after_pop < DEPTH_C) begin
          req_pc_d = fetch_pc_q;
          state_d  = FETCH;
        end
      end
      FETCH: begin
        if (jump_en) begin
          fetch_pc_d = jump_addr;
          state_d    = imem_ack ? IDLE : FLUSH;
        end else if (imem_ack) begin
          fetch_pc_d = next_pc;
          if (count_d < DEPTH_C) begin
            req_pc_d = next_pc;
          end else begin
            state_d = IDLE;
          end
        end
      end
      FLUSH: begin
        // The abandoned request is held on the bus until memory acknowledges it.
        if (jump_en) begin
          fetch_pc_d = jump_addr;
        end
        if (imem_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (jump_en) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end
  end

  // State and buffer registers; reset abandons any outstanding request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_pc_q[i]    <= '0;
        buf_instr_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_pc_q    <= req_pc_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
    end
  end

  // A push into a full buffer would overwrite the oldest undelivered instruction.
  a_no_push_when_full : assert property (@(posedge clk) disable iff (reset) push |-> (count_q < DEPTH_C));

endmodule
